// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiply sequencer.
// Chunk geometry lives here so the sequencer and chunk multiplier always agree.
package mul_pkg;

   localparam int CHUNK_W = 10;
   localparam int N_CHUNK = 4;
   localparam int ACC_W   = 64;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_funct_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      NEG  = 2'b10,
      DONE = 2'b11
   } mul_state_e;

   // The top chunk only carries the two leftover magnitude bits.
   function automatic logic [CHUNK_W-1:0] get_chunk(input logic [31:0] mag,
                                                    input logic [1:0]  k);
      logic [CHUNK_W-1:0] c;
      case (k)
         2'd0:    c = mag[9:0];
         2'd1:    c = mag[19:10];
         2'd2:    c = mag[29:20];
         default: c = {8'b0, mag[31:30]};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mul_chunk10.sv
// Purely combinational 10x10 unsigned multiplier producing a 20-bit product.
module mul_chunk10
   import mul_pkg::*;
(
   input  logic [CHUNK_W-1:0]   a,
   input  logic [CHUNK_W-1:0]   b,
   output logic [2*CHUNK_W-1:0] p
);

   assign p = {{CHUNK_W{1'b0}}, a} * {{CHUNK_W{1'b0}}, b};

endmodule

// File: rtl/mul_seq.sv
// Iterative RV32M multiply: magnitudes are stepped through one 10x10 chunk
// multiplier over 16 cycles, then sign-corrected and returned over valid/ready.
module mul_seq
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  funct,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   mul_state_e          state, state_nxt;
   logic [3:0]          cnt;
   logic [ACC_W-1:0]    acc;
   mul_funct_e          funct_q;
   logic                neg_q;
   logic [31:0]         mag1_q, mag2_q;

   mul_funct_e          funct_in;
   logic                s1, s2, neg_in;
   logic [31:0]         mag1_in, mag2_in;

   logic [CHUNK_W-1:0]   chunk_a, chunk_b;
   logic [2*CHUNK_W-1:0] prod;
   logic [5:0]           shamt;
   logic [ACC_W-1:0]     term;
   logic                 zero_op;

   assign funct_in = mul_funct_e'(funct);
   assign s1       = (funct_in == MULH) || (funct_in == MULHSU);
   assign s2       = (funct_in == MULH);
   assign neg_in   = (s1 & rs1[31]) ^ (s2 & rs2[31]);
   // -0x80000000 wraps to 0x80000000, which is the right unsigned magnitude.
   assign mag1_in  = (s1 & rs1[31]) ? -rs1 : rs1;
   assign mag2_in  = (s2 & rs2[31]) ? -rs2 : rs2;

   assign chunk_a = get_chunk(mag1_q, cnt[3:2]);
   assign chunk_b = get_chunk(mag2_q, cnt[1:0]);

   mul_chunk10 u_chunk (
      .a (chunk_a),
      .b (chunk_b),
      .p (prod)
   );

   assign shamt   = 6'd10 * ({4'b0, cnt[3:2]} + {4'b0, cnt[1:0]});
   assign term    = {{(ACC_W-2*CHUNK_W){1'b0}}, prod} << shamt;
   assign zero_op = (mag1_q == 32'd0) || (mag2_q == 32'd0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = (funct_q == MUL) ? acc[31:0] : acc[63:32];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = RUN;
         RUN: begin
            if (zero_op)           state_nxt = DONE;
            else if (cnt == 4'd15) state_nxt = NEG;
         end
         NEG:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= 4'd0;
         acc     <= '0;
         funct_q <= MUL;
         neg_q   <= 1'b0;
         mag1_q  <= 32'd0;
         mag2_q  <= 32'd0;
      end else if (flush) begin
         cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  funct_q <= funct_in;
                  neg_q   <= neg_in;
                  mag1_q  <= mag1_in;
                  mag2_q  <= mag2_in;
                  acc     <= '0;
                  cnt     <= 4'd0;
               end
            end
            RUN: begin
               if (zero_op) begin
                  acc <= '0;
               end else begin
                  acc <= acc + term;
                  cnt <= cnt + 4'd1;
               end
            end
            NEG: begin
               if (neg_q) acc <= ~acc + 64'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random-sweep bench for mul_seq; outputs sampled 1 time unit after posedge.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  funct = 2'b00;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   mul_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct     (funct),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      sa = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      sb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = sa * sb;
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Called 1 unit after a posedge with the sequencer idle.
   task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit retire, output logic [31:0] res, output int lat);
      funct = f; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      if (retire) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul_basic;
      logic [31:0] r;
      int lat;
      do_op(2'b00, 32'd7, 32'd6, 1'b0, r, lat);
      n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL mul7x6_latency: got %0d want 17", lat); end
      n_cmp++; if (r !== 32'h0000002A) begin n_bad++; $display("FAIL mul7x6_result: got %h want 0000002a", r); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul7x6_busy_done: got %b want 1", busy); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul7x6_busy_after: got %b want 0", busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul7x6_valid_after: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mul7x6_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_signed_vectors;
      logic [1:0]  vf [6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
      logic [31:0] va [6] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] vb [6] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
      logic [31:0] ve [6] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF};
      logic [31:0] r;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(vf[i], va[i], vb[i], 1'b1, r, lat);
         n_cmp++; if (r !== ve[i]) begin n_bad++; $display("FAIL signed_vec%0d_result: got %h want %h", i, r, ve[i]); end
         n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL signed_vec%0d_latency: got %0d want 17", i, lat); end
      end
   endtask

   task automatic test_early_out_hold;
      logic [31:0] r;
      int lat;
      do_op(2'b01, 32'h00000000, 32'h12345678, 1'b0, r, lat);
      n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL early_latency: got %0d want 1", lat); end
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL early_result: got %h want 0", r); end
      for (int c = 0; c < 5; c++) begin
         in_valid = (c % 2 == 0);
         funct = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d_out_valid: got %b want 1", c, out_valid); end
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d_in_ready: got %b want 0", c, in_ready); end
         n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL hold%0d_result: got %h want 0", c, result); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_retire_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_retire_out_valid: got %b want 0", out_valid); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_no_ghost_busy: got %b want 0", busy); end
   endtask

   task automatic test_flush;
      logic [31:0] r;
      int lat;
      funct = 2'b00; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      do_op(2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b1, r, lat);
      n_cmp++; if (r !== 32'h0B00EA4E) begin n_bad++; $display("FAIL post_flush_mulhu: got %h want 0b00ea4e", r); end
      n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL post_flush_latency: got %0d want 17", lat); end
   endtask

   task automatic test_reset_in_done;
      logic [31:0] r;
      int lat;
      do_op(2'b00, 32'd7, 32'd6, 1'b0, r, lat);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_done_pre_valid: got %b want 1", out_valid); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_done_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_done_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_done_busy: got %b want 0", busy); end
      n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL rst_done_result: got %h want 0", result); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [1:0]  f;
      logic [31:0] a, b, r, exp_r;
      int lat, exp_lat, sel;
      for (int n = 0; n < 1000; n++) begin
         f = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 15);
         if (sel == 0) a = 32'd0;
         if (sel == 1) b = 32'd0;
         if (sel == 2) a = 32'h80000000;
         if (sel == 3) b = 32'hFFFFFFFF;
         exp_r   = ref_mul(f, a, b);
         exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 17;
         do_op(f, a, b, 1'b1, r, lat);
         n_cmp++; if (r !== exp_r) begin n_bad++; $display("FAIL sweep%0d_result f=%0d a=%h b=%h: got %h want %h", n, f, a, b, r, exp_r); end
         n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL sweep%0d_latency: got %0d want %0d", n, lat, exp_lat); end
      end
   endtask

   initial begin
      test_reset;
      test_mul_basic;
      test_signed_vectors;
      test_early_out_hold;
      test_flush;
      test_reset_in_done;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
